// File: rtl/regbank_wb_queue_pkg.sv
// Shared parameters and request payload for the register-bank write-back queue.
package regbank_wb_queue_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned NREG  = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] dr;
    logic [DW-1:0] data;
  } wb_req_t;

  localparam int unsigned REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/regbank_wb_queue_if.sv
// Producer-side request bus plus bank-side write port and hazard flags.
interface regbank_wb_queue_if;
  import regbank_wb_queue_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_dr;
  logic [DW-1:0]   in_data;
  logic            write;
  logic [AW-1:0]   dr;
  logic [DW-1:0]   wrData;
  logic [NREG-1:0] pending;
  logic [CW-1:0]   count;

  modport master (
    output flush, in_valid, in_dr, in_data,
    input  in_ready, write, dr, wrData, pending, count
  );

  modport slave (
    input  flush, in_valid, in_dr, in_data,
    output in_ready, write, dr, wrData, pending, count
  );

endinterface

// File: rtl/regbank_wb_queue_wb_fifo.sv
// Generic synchronous FIFO; exposes every slot and its valid bit for hazard scans.
module wb_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [W-1:0]              din_i,
  output logic [W-1:0]              dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [DEPTH-1:0]          valid_o,
  output logic [DEPTH-1:0][W-1:0]   entries_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;
  logic [PW-1:0] off;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wr_q] <= din_i;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_q;
      valid_o[i]   = (CW'(off) < cnt_q);
      entries_o[i] = mem_q[i];
    end
  end

endmodule

// File: rtl/regbank_wb_queue.sv
// Write-back queue feeding the register bank write port, with per-register pending flags.
module regbank_wb_queue
  import regbank_wb_queue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  regbank_wb_queue_if.slave  bus
);

  wb_req_t                      in_req;
  wb_req_t                      head;
  wb_req_t                      ent;
  logic [REQ_W-1:0]             head_raw;
  logic [DEPTH-1:0][REQ_W-1:0]  entries;
  logic [DEPTH-1:0]             valid;
  logic                         full, empty;
  logic [CW-1:0]                fifo_cnt;
  logic                         push, pop;

  logic            write_q, write_d;
  logic [AW-1:0]   dr_q, dr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NREG-1:0] pending_c;

  assign in_req.dr   = bus.in_dr;
  assign in_req.data = bus.in_data;
  assign head        = wb_req_t'(head_raw);
  assign push        = bus.in_valid && !full && !bus.flush;
  assign pop         = !empty && !bus.flush;

  wb_fifo #(
    .W     (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.flush),
    .push_i    (push),
    .pop_i     (pop),
    .din_i     (REQ_W'(in_req)),
    .dout_o    (head_raw),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (fifo_cnt),
    .valid_o   (valid),
    .entries_o (entries)
  );

  // Output stage: the head is staged whenever present; dr/wrData hold when idle.
  always_comb begin
    write_d = 1'b0;
    dr_d    = dr_q;
    data_d  = data_q;
    if (!bus.flush && !empty) begin
      write_d = 1'b1;
      dr_d    = head.dr;
      data_d  = head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      dr_q    <= '0;
      data_q  <= '0;
    end else begin
      write_q <= write_d;
      dr_q    <= dr_d;
      data_q  <= data_d;
    end
  end

  // A register is pending while any live slot or the staged write targets it.
  always_comb begin
    pending_c = '0;
    ent       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent = wb_req_t'(entries[i]);
      if (valid[i]) pending_c[ent.dr] = 1'b1;
    end
    if (write_q) pending_c[dr_q] = 1'b1;
  end

  assign bus.in_ready = !full;
  assign bus.write    = write_q;
  assign bus.dr       = dr_q;
  assign bus.wrData   = data_q;
  assign bus.pending  = pending_c;
  assign bus.count    = fifo_cnt;

endmodule

// File: tb/tb_regbank_wb_queue.sv
// Randomized and directed bench for regbank_wb_queue against a queue-based model.
module tb_regbank_wb_queue;
  import regbank_wb_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regbank_wb_queue_if bus ();

  regbank_wb_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: queued requests, the staged write, and the bank it commits into.
  wb_req_t       mq[$];
  logic          m_write;
  logic [AW-1:0] m_dr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] bank [NREG];
  int            checks = 0;
  int            errors = 0;
  logic          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] m_pending();
    logic [NREG-1:0] p = '0;
    foreach (mq[i]) p[mq[i].dr] = 1'b1;
    if (m_write) p[m_dr] = 1'b1;
    return p;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_write = 1'b0;
    m_dr    = '0;
    m_data  = '0;
  endtask

  task automatic model_step();
    wb_req_t r;
    logic    ready;
    if (rst) return;
    if (m_write) bank[m_dr] = m_data;
    ready = (mq.size() < DEPTH);
    if (bus.flush) begin
      mq.delete();
      m_write = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        r       = mq.pop_front();
        m_write = 1'b1;
        m_dr    = r.dr;
        m_data  = r.data;
      end else begin
        m_write = 1'b0;
      end
      if (bus.in_valid && ready) begin
        r.dr   = bus.in_dr;
        r.data = bus.in_data;
        mq.push_back(r);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x,
                     input logic fl);
    bus.in_valid = v;
    bus.in_dr    = d;
    bus.in_data  = x;
    bus.flush    = fl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("write",    64'(bus.write),    64'(m_write));
      chk("dr",       64'(bus.dr),       64'(m_dr));
      chk("wrData",   64'(bus.wrData),   64'(m_data));
      chk("count",    64'(bus.count),    64'(mq.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
      chk("pending",  64'(bus.pending),  64'(m_pending()));
    end
  end

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_dr    = '0;
    bus.in_data  = '0;
    for (int r = 0; r < NREG; r++) bank[r] = '0;
    m_reset();
    #1;
    chk("rst_write",   64'(bus.write),   64'(0));
    chk("rst_count",   64'(bus.count),   64'(0));
    chk("rst_pending", 64'(bus.pending), 64'(0));
    chk("rst_dr",      64'(bus.dr),      64'(0));
    chk("rst_wrData",  64'(bus.wrData),  64'(0));
    idle();
    idle();
    rst    = 1'b0;
    cmp_en = 1'b1;
    idle();

    // Single write to R2.
    cyc(1'b1, 2'd2, 32'hDEADBEEF, 1'b0);
    chk("single_cnt",   64'(bus.count),   64'(1));
    chk("single_w0",    64'(bus.write),   64'(0));
    chk("single_pend0", 64'(bus.pending), 64'h4);
    idle();
    chk("single_w1",    64'(bus.write),   64'(1));
    chk("single_dr",    64'(bus.dr),      64'(2));
    chk("single_data",  64'(bus.wrData),  64'hDEADBEEF);
    chk("single_pend1", 64'(bus.pending), 64'h4);
    idle();
    chk("single_w2",    64'(bus.write),   64'(0));
    chk("single_pend2", 64'(bus.pending), 64'(0));
    chk("single_bank",  64'(bank[2]),     64'hDEADBEEF);

    // Same-register ordering.
    cyc(1'b1, 2'd1, 32'h1, 1'b0);
    cyc(1'b1, 2'd1, 32'h2, 1'b0);
    chk("same_w1",    64'(bus.wrData),  64'h1);
    chk("same_cnt",   64'(bus.count),   64'(1));
    chk("same_pend1", 64'(bus.pending), 64'h2);
    idle();
    chk("same_w2",    64'(bus.wrData),  64'h2);
    chk("same_pend2", 64'(bus.pending), 64'h2);
    idle();
    chk("same_pend3", 64'(bus.pending), 64'(0));
    chk("same_bank",  64'(bank[1]),     64'h2);

    // Flush with one staged, one queued and a concurrent push.
    cyc(1'b1, 2'd0, 32'hA, 1'b0);
    cyc(1'b1, 2'd3, 32'hB, 1'b0);
    chk("flush_pend_pre", 64'(bus.pending), 64'h9);
    cyc(1'b1, 2'd2, 32'hC, 1'b1);
    chk("flush_cnt",  64'(bus.count),   64'(0));
    chk("flush_w",    64'(bus.write),   64'(0));
    chk("flush_pend", 64'(bus.pending), 64'(0));
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("flush_stale", 64'(bus.write), 64'(0));
    end
    chk("flush_bank0", 64'(bank[0]), 64'hA);
    chk("flush_bank3", 64'(bank[3]), 64'(0));

    // Streaming: one push per cycle.
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, AW'($urandom_range(0, NREG - 1)), $urandom, 1'b0);
      chk("stream_cnt", 64'(bus.count <= CW'(1)), 64'(1));
      if (k > 0) chk("stream_w", 64'(bus.write), 64'(1));
    end

    // Reset in the middle of a burst.
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk("midrst_write",   64'(bus.write),   64'(0));
    chk("midrst_pending", 64'(bus.pending), 64'(0));
    chk("midrst_count",   64'(bus.count),   64'(0));
    cyc(1'b1, 2'd3, 32'h5, 1'b0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("midrst_nowrite", 64'(bus.write), 64'(0));
    end

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, NREG - 1)), $urandom,
          1'($urandom_range(0, 19) == 0));
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
